// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered RISC-V decode stage with valid/ready handshakes, sign-extended immediates and a saturating illegal-instruction counter
// Ports:
//   clk, rst                      clock; synchronous active-high reset
//   in_valid_i/in_ready_o/instr_i upstream handshake and raw instruction word
//   flush_i                       drop the held entry and block acceptance this cycle
//   out_valid_o/out_ready_i       downstream handshake
//   opcode_o..funct7b5_o          instruction fields
//   sel_ext_o/imm_o/illegal_o     immediate format, XLEN immediate, unsupported opcode
//   ill_count_o                   saturating count of accepted illegal instructions
module instr_decode_stage #(
  parameter int XLEN      = 32,
  parameter int EXT_OPS   = 1,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [31:0]          instr_i,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [6:0]           opcode_o,
  output logic [4:0]           rd_o,
  output logic [4:0]           rs1_o,
  output logic [4:0]           rs2_o,
  output logic [2:0]           funct3_o,
  output logic                 funct7b5_o,
  output logic [2:0]           sel_ext_o,
  output logic [XLEN-1:0]      imm_o,
  output logic                 illegal_o,
  output logic [ILL_CNT_W-1:0] ill_count_o
);
  logic [6:0] op;
  logic ext, is_i, is_s, is_b, is_j, is_u, is_r, accept, ill_d;
  logic [2:0] sel_d;
  logic [31:0] imm32_d;
  logic [XLEN-1:0] imm_d;
  logic out_valid_q, ill_q;
  logic [2:0] sel_q;
  logic [XLEN-1:0] imm_q;
  logic [25:0] fld_q;
  logic [ILL_CNT_W-1:0] ill_cnt_q;
  assign op = instr_i[6:0];
  assign ext = EXT_OPS != 0;
  assign is_i = op == 7'b0010011 || op == 7'b0000011 || (ext && op == 7'b1100111);
  assign is_s = op == 7'b0100011;
  assign is_b = op == 7'b1100011;
  assign is_j = op == 7'b1101111;
  assign is_u = op == 7'b0110111 || (ext && op == 7'b0010111);
  assign is_r = op == 7'b0110011;
  assign ill_d = !(is_i || is_s || is_b || is_j || is_u || is_r);
  assign in_ready_o = !flush_i && (!out_valid_q || out_ready_i);
  assign accept = in_valid_i && in_ready_o;
  always_comb begin
    sel_d = is_s ? 3'b001 : is_b ? 3'b010 : is_j ? 3'b011 : is_u ? 3'b100 : is_r ? 3'b111 : 3'b000;
    imm32_d = is_i ? {{20{instr_i[31]}}, instr_i[31:20]} :
              is_s ? {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]} :
              is_b ? {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0} :
              is_j ? {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0} :
              is_u ? {instr_i[31:12], 12'b0} : 32'b0;
    imm_d = XLEN'($signed(imm32_d));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ill_q <= 1'b0;
      sel_q <= 3'b000;
      imm_q <= '0;
      fld_q <= '0;
      ill_cnt_q <= '0;
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      ill_q <= ill_d;
      sel_q <= sel_d;
      imm_q <= imm_d;
      fld_q <= {instr_i[30], instr_i[24:0]};
      ill_cnt_q <= ill_cnt_q + ILL_CNT_W'(ill_d && !(&ill_cnt_q));
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end
  assign out_valid_o = out_valid_q;
  assign opcode_o = fld_q[6:0];
  assign rd_o = fld_q[11:7];
  assign funct3_o = fld_q[14:12];
  assign rs1_o = fld_q[19:15];
  assign rs2_o = fld_q[24:20];
  assign funct7b5_o = fld_q[25];
  assign sel_ext_o = sel_q;
  assign imm_o = imm_q;
  assign illegal_o = ill_q;
  assign ill_count_o = ill_cnt_q;
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: table-driven and directed checks of instr_decode_stage in two configurations
module tb_instr_decode_stage;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] instr = '0;
  logic a_rdy, a_vld, a_f7, a_ill, b_rdy, b_vld, b_f7, b_ill;
  logic [6:0] a_op, b_op;
  logic [4:0] a_rd, a_rs1, a_rs2, b_rd, b_rs1, b_rs2;
  logic [2:0] a_f3, a_sel, b_f3, b_sel;
  logic [31:0] a_imm;
  logic [63:0] b_imm;
  logic [7:0] a_cnt;
  logic [1:0] b_cnt;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  instr_decode_stage dut_a (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(a_rdy), .instr_i(instr),
    .flush_i(flush), .out_valid_o(a_vld), .out_ready_i(out_ready), .opcode_o(a_op),
    .rd_o(a_rd), .rs1_o(a_rs1), .rs2_o(a_rs2), .funct3_o(a_f3), .funct7b5_o(a_f7),
    .sel_ext_o(a_sel), .imm_o(a_imm), .illegal_o(a_ill), .ill_count_o(a_cnt)
  );
  instr_decode_stage #(.XLEN(64), .EXT_OPS(0), .ILL_CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(b_rdy), .instr_i(instr),
    .flush_i(flush), .out_valid_o(b_vld), .out_ready_i(out_ready), .opcode_o(b_op),
    .rd_o(b_rd), .rs1_o(b_rs1), .rs2_o(b_rs2), .funct3_o(b_f3), .funct7b5_o(b_f7),
    .sel_ext_o(b_sel), .imm_o(b_imm), .illegal_o(b_ill), .ill_count_o(b_cnt)
  );
  typedef struct {
    logic [31:0] ins;
    logic [2:0]  sel;
    logic [31:0] imm;
    logic        ill;
    logic [2:0]  sel2;
    logic [63:0] imm2;
    logic        ill2;
  } vec_t;
  vec_t v[10];
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset(input string n);
    chk({n, " a_vld"}, a_vld, 0);
    chk({n, " a_sel"}, a_sel, 0);
    chk({n, " a_imm"}, a_imm, 0);
    chk({n, " a_ill"}, a_ill, 0);
    chk({n, " a_cnt"}, a_cnt, 0);
    chk({n, " a_fields"}, {a_op, a_rd, a_rs1, a_rs2, a_f3, a_f7}, 0);
    chk({n, " b_vld"}, b_vld, 0);
    chk({n, " b_imm"}, b_imm, 0);
    chk({n, " b_cnt"}, b_cnt, 0);
  endtask
  initial begin
    v[0] = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 1'b0, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    v[1] = '{32'h0020A423, 3'd1, 32'h00000008, 1'b0, 3'd1, 64'h8, 1'b0};
    v[2] = '{32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 1'b0, 3'd2, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    v[3] = '{32'h123452B7, 3'd4, 32'h12345000, 1'b0, 3'd4, 64'h12345000, 1'b0};
    v[4] = '{32'h0000006F, 3'd3, 32'h00000000, 1'b0, 3'd3, 64'h0, 1'b0};
    v[5] = '{32'h000080E7, 3'd0, 32'h00000000, 1'b0, 3'd0, 64'h0, 1'b1};
    v[6] = '{32'hFFFFF517, 3'd4, 32'hFFFFF000, 1'b0, 3'd0, 64'h0, 1'b1};
    v[7] = '{32'h40B50533, 3'd7, 32'h00000000, 1'b0, 3'd7, 64'h0, 1'b0};
    v[8] = '{32'h00000000, 3'd0, 32'h00000000, 1'b1, 3'd0, 64'h0, 1'b1};
    v[9] = '{32'hFF9FF06F, 3'd3, 32'hFFFFFFF8, 1'b0, 3'd3, 64'hFFFFFFFFFFFFFFF8, 1'b0};
    tick;
    tick;
    chk_reset("reset");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      out_ready = 1'b1;
      instr = v[i].ins;
      tick;
      chk($sformatf("v%0d a_vld", i), a_vld, 1);
      chk($sformatf("v%0d a_sel", i), a_sel, v[i].sel);
      chk($sformatf("v%0d a_imm", i), a_imm, v[i].imm);
      chk($sformatf("v%0d a_ill", i), a_ill, v[i].ill);
      chk($sformatf("v%0d a_fields", i), {a_op, a_rd, a_f3, a_rs1, a_rs2, a_f7},
          {v[i].ins[6:0], v[i].ins[11:7], v[i].ins[14:12], v[i].ins[19:15], v[i].ins[24:20], v[i].ins[30]});
      chk($sformatf("v%0d b_sel", i), b_sel, v[i].sel2);
      chk($sformatf("v%0d b_imm", i), b_imm, v[i].imm2);
      chk($sformatf("v%0d b_ill", i), b_ill, v[i].ill2);
    end
    chk("table a_cnt", a_cnt, 1);
    chk("table b_cnt sat", b_cnt, 3);
    out_ready = 1'b0;
    instr = 32'h0000006F;
    #1;
    chk("stall in_ready", a_rdy, 0);
    tick;
    chk("stall vld", a_vld, 1);
    chk("stall sel", a_sel, 3);
    chk("stall imm", a_imm, 32'hFFFFFFF8);
    out_ready = 1'b1;
    #1;
    chk("release in_ready", a_rdy, 1);
    tick;
    chk("jal vld", a_vld, 1);
    chk("jal sel", a_sel, 3);
    chk("jal imm", a_imm, 0);
    in_valid = 1'b0;
    tick;
    chk("drain vld", a_vld, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      instr = 32'h0;
      tick;
      chk($sformatf("ill%0d b_cnt", i), b_cnt, (i < 3) ? i + 1 : 3);
      chk($sformatf("ill%0d a_cnt", i), a_cnt, i + 1);
      chk($sformatf("ill%0d a_ill", i), a_ill, 1);
    end
    out_ready = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush in_ready", a_rdy, 0);
    tick;
    chk("flush a_vld", a_vld, 0);
    chk("flush b_vld", b_vld, 0);
    chk("flush a_cnt", a_cnt, 5);
    chk("flush b_cnt", b_cnt, 3);
    flush = 1'b0;
    out_ready = 1'b1;
    instr = 32'hFFF00093;
    tick;
    chk("pre-rst vld", a_vld, 1);
    rst = 1'b1;
    instr = 32'h0020A423;
    tick;
    chk_reset("midrst");
    rst = 1'b0;
    instr = 32'h123452B7;
    tick;
    chk("post-rst vld", a_vld, 1);
    chk("post-rst sel", a_sel, 4);
    chk("post-rst imm", a_imm, 32'h12345000);
    chk("post-rst rd", a_rd, 5);
    in_valid = 1'b0;
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
